fifo_uart_tx: RTL

Serial transmitter draining the 8-entry byte FIFO from its read side: whenever the FIFO is non-empty and transmission is enabled, it pops one byte and sends it as an 8N1 UART frame, LSB first. It sits between the FIFO output and the board TX pin and returns classification/result bytes to the host PC. Frames are sent back-to-back with a one-cycle load gap while bytes remain queued.

---
 rtl/fifo_uart_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains the byte FIFO from its read side. Whenever the FIFO holds data and
//   transmission is enabled, it pops one byte and sends it as an 8N1 UART
//   frame, LSB first. Frames go back-to-back with a single load cycle between
//   them while bytes remain queued.
//
// Parameters
//   BAUD_DIV   clocks per bit, 2..65535 (434 = 50 MHz / 115200)
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tx_en      permits starting new frames; never aborts one in progress
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO head entry, valid while fifo_empty is low
//   fifo_r_en  pop strobe, one-cycle registered pulse (LOAD state)
//   tx         serial line, idle high, registered
//   tx_busy    high in every state except IDLE
//   tx_done    one-cycle pulse on the last cycle of each stop bit
module fifo_uart_tx #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_r_en,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   // tx_done is registered, so it is raised one cycle ahead of the terminal count
   localparam logic [15:0] BAUD_PRE  = 16'(BAUD_DIV - 2);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   state_t      r_state;
   logic [15:0] r_baud_cnt;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic        r_tx;
   logic        r_fifo_r_en;
   logic        r_busy;
   logic        r_done;

   logic w_baud_term;
   logic w_can_start;

   assign w_baud_term = (r_baud_cnt == BAUD_LAST);
   assign w_can_start = tx_en & ~fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_baud_cnt  <= 16'd0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'd0;
         r_tx        <= 1'b1;
         r_fifo_r_en <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_fifo_r_en <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_can_start) begin
                  r_state     <= LOAD;
                  r_fifo_r_en <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            LOAD: begin
               // FIFO pops on this same edge, so fifo_data is still the head
               r_shift    <= fifo_data;
               r_baud_cnt <= 16'd0;
               r_bit_cnt  <= 3'd0;
               r_tx       <= 1'b0;
               r_state    <= START;
            end
            START: begin
               if (w_baud_term) begin
                  r_baud_cnt <= 16'd0;
                  r_tx       <= r_shift[0];
                  r_state    <= DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (w_baud_term) begin
                  r_baud_cnt <= 16'd0;
                  r_shift    <= {1'b0, r_shift[7:1]};
                  if (r_bit_cnt == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end
            STOP: begin
               r_tx <= 1'b1;
               if (r_baud_cnt == BAUD_PRE) r_done <= 1'b1;
               if (w_baud_term) begin
                  r_baud_cnt <= 16'd0;
                  if (w_can_start) begin
                     r_state     <= LOAD;
                     r_fifo_r_en <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_r_en = r_fifo_r_en;
   assign tx        = r_tx;
   assign tx_busy   = r_busy;
   assign tx_done   = r_done;

endmodule
